ci_dispatch: RTL
================

# ci_dispatch

Custom-instruction dispatch stage between the CPU custom-instruction port and a bank of custom-instruction slaves such as the profiling counter block. It latches each CPU request and issues a one-cycle start pulse to the slave bank. It waits for the addressed slave's done, registers that slave's result, and returns a single-cycle done/result pair to the CPU. Unmapped IDs are answered immediately with zero; hung slaves are terminated by an optional timeout.

## Interface
- nrOfSlaves, 4: number of slaves, 1..16.
- baseId, 8'h00: ciN of slave 0; slave i answers ciN == baseId + i.
- timeoutCycles, 16'd255: max ACTIVE cycles before forced completion, ≥1.

- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpuStart  in  1  request strobe, one cycle.
- cpuCiN  in  8  custom-instruction ID.
- cpuValueA  in  32  operand A.
- cpuValueB  in  32  operand B.
- cpuDone  out  1  completion strobe, one cycle.
- cpuResult  out  32  result; 0 whenever cpuDone is 0.
- ciStart  out  1  start pulse broadcast to all slaves.
- ciN  out  8  latched ID to slaves.
- ciValueA  out  32  latched operand A.
- ciValueB  out  32  latched operand B.
- ciDoneVec  in  nrOfSlaves  done of slave i at bit i.
- ciResultVec  in  32*nrOfSlaves  result of slave i at bits [32i+31:32i].
- busy  out  1  high in ACTIVE and RESP.
- timeoutFlag  out  1  sticky, set on any timeout.

## Operation
- States: IDLE, ACTIVE, RESP. Reset → IDLE.
- IDLE, cpuStart=1, mapped ID:
  - Mapped means baseId ≤ cpuCiN < baseId+nrOfSlaves, compared in 9 bits so there is no wrap above 8'hFF.
  - Latch cpuCiN/A/B into ciN/ciValueA/ciValueB.
  - Latch sel = cpuCiN − baseId.
  - Clear the timeout counter; go to ACTIVE.
- IDLE, cpuStart=1, unmapped ID: go to RESP with result 32'h0. ciStart is never asserted.
- ACTIVE:
  - ciStart=1 in the first ACTIVE cycle only.
  - Each edge samples ciDoneVec[sel]. If 1, capture ciResultVec[sel] and go to RESP.
  - Done bits of other slaves are ignored.
- RESP: cpuDone=1 and cpuResult = captured value for exactly one cycle, then IDLE.
- cpuStart outside IDLE is ignored: no queueing, no latch update.
- ciN/ciValueA/ciValueB hold their latched values until the next accepted request.
- Reset is asserted asynchronously at any point, including mid-ACTIVE:
  - All outputs go to 0 immediately and state goes to IDLE.
  - timeoutFlag clears. The pending request is dropped with no cpuDone.

## Timing
- Reset values:
  - cpuDone=0, cpuResult=0, ciStart=0, ciN=0, ciValueA=0, ciValueB=0.
  - busy=0, timeoutFlag=0.
- All outputs are registered; no combinational path from inputs to outputs.
- cpuStart high in cycle k: ciStart and busy high in cycle k+1.
- A slave that raises done in cycle k+1 gives cpuDone in cycle k+2, so minimum mapped latency is 2.
- A slave done in cycle k+1+d gives cpuDone in cycle k+2+d.
- Unmapped ID: cpuDone in cycle k+1, result 0.
- Back-to-back: the next cpuStart is accepted at the earliest in the cycle after cpuDone, i.e. in IDLE.

## Configuration
- CI_DISPATCH_TIMEOUT_EN defined:
  - A 16-bit counter increments each ACTIVE cycle without done.
  - When the count equals timeoutCycles, go to RESP with result 32'hFFFFFFFF and set timeoutFlag.
  - If done and timeout coincide, done wins.
- Undefined: no counter. ACTIVE waits indefinitely; timeoutFlag is tied 0.

## Test plan
- Reset: hold reset 10 ps mid-simulation with outputs active → every output is 0 and state is IDLE on the same edge, with no clock needed.
- Mapped request, baseId=8'h00:
  - Stimulus: cpuStart with cpuCiN=8'h02, cpuValueA=32'h1, cpuValueB=32'hF; slave 2 done in the first ACTIVE cycle with result 32'h1234.
  - Response: ciStart is one cycle with ciValueB=32'hF; cpuDone exactly 2 cycles after cpuStart with cpuResult=32'h1234.
- Slave delay: slave 1 done 5 cycles after ciStart → cpuDone at cycle 7 relative to cpuStart. Slave 0 done pulses meanwhile are ignored.
- Unmapped: cpuCiN=8'h09 with nrOfSlaves=4 → cpuDone the next cycle, cpuResult=0, ciStart never high.
- Timeout, macro defined, timeoutCycles=8: slave silent → cpuDone with 32'hFFFFFFFF and timeoutFlag=1 stays high until reset. A second cpuStart issued while busy is ignored.
- Wrap: baseId=8'hFE, nrOfSlaves=4, cpuCiN=8'h01 → unmapped response 0. cpuCiN=8'hFF → sel=1, mapped.

Source files
------------

// File: rtl/ci_dispatch.sv
// ci_dispatch: custom-instruction dispatch stage between the CPU CI port and
// a bank of CI slaves. Latches each request, pulses ciStart, waits for the
// addressed slave's done and returns a one-cycle cpuDone/cpuResult pair.
// Unmapped IDs are answered at once with zero.
// Optional feature macro: CI_DISPATCH_TIMEOUT_EN (forced completion of a hung
// slave after timeoutCycles ACTIVE cycles, result all ones, sticky flag).
`timescale 1ns/1ps

module ci_dispatch #(
   parameter int unsigned nrOfSlaves    = 4,
   parameter logic [7:0]  baseId        = 8'h00,
   parameter logic [15:0] timeoutCycles = 16'd255
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cpuStart,
   input  logic [7:0]                 cpuCiN,
   input  logic [31:0]                cpuValueA,
   input  logic [31:0]                cpuValueB,
   output logic                       cpuDone,
   output logic [31:0]                cpuResult,
   output logic                       ciStart,
   output logic [7:0]                 ciN,
   output logic [31:0]                ciValueA,
   output logic [31:0]                ciValueB,
   input  logic [nrOfSlaves-1:0]      ciDoneVec,
   input  logic [32*nrOfSlaves-1:0]   ciResultVec,
   output logic                       busy,
   output logic                       timeoutFlag
);

   localparam int unsigned SelW = (nrOfSlaves > 1) ? $clog2(nrOfSlaves) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   logic [SelW-1:0] sel;
   logic [9:0]      diff;
   logic            mapped;
   logic            sel_done;
   logic [31:0]     sel_result;

`ifdef CI_DISPATCH_TIMEOUT_EN
   logic [15:0]     tcnt;
`else
   logic            unused_timeout;
   assign unused_timeout = ^timeoutCycles;
`endif

   // Address decode (10-bit difference: bit 9 is the borrow, so IDs below
   // baseId and IDs past 8'hFF never alias) and selected-slave muxing.
   always_comb begin
      diff       = {2'b00, cpuCiN} - {2'b00, baseId};
      mapped     = ~diff[9] && (diff[8:0] < 9'(nrOfSlaves));
      sel_done   = ciDoneVec[sel];
      sel_result = ciResultVec[32*int'(sel) +: 32];
   end

   // Dispatch FSM; every output is a register updated here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sel         <= '0;
         cpuDone     <= 1'b0;
         cpuResult   <= '0;
         ciStart     <= 1'b0;
         ciN         <= '0;
         ciValueA    <= '0;
         ciValueB    <= '0;
         busy        <= 1'b0;
         timeoutFlag <= 1'b0;
`ifdef CI_DISPATCH_TIMEOUT_EN
         tcnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cpuDone   <= 1'b0;
               cpuResult <= '0;
               if (cpuStart) begin
                  busy <= 1'b1;
                  if (mapped) begin
                     ciN      <= cpuCiN;
                     ciValueA <= cpuValueA;
                     ciValueB <= cpuValueB;
                     sel      <= diff[SelW-1:0];
                     ciStart  <= 1'b1;
`ifdef CI_DISPATCH_TIMEOUT_EN
                     tcnt     <= '0;
`endif
                     state    <= ACTIVE;
                  end else begin
                     cpuDone   <= 1'b1;
                     cpuResult <= '0;
                     state     <= RESP;
                  end
               end
            end
            ACTIVE: begin
               ciStart <= 1'b0;
               if (sel_done) begin
                  cpuDone   <= 1'b1;
                  cpuResult <= sel_result;
                  state     <= RESP;
               end
`ifdef CI_DISPATCH_TIMEOUT_EN
               else if (tcnt == timeoutCycles - 16'd1) begin
                  cpuDone     <= 1'b1;
                  cpuResult   <= '1;
                  timeoutFlag <= 1'b1;
                  state       <= RESP;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
`endif
            end
            RESP: begin
               cpuDone   <= 1'b0;
               cpuResult <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
